// File: rtl/conv_8_32_if.sv
// Byte-serial receive bus for the 8->32 deserializer.
// The slave side is the deserializer and the master side is whatever drives it.
interface conv_8_32_if;
    logic        valid_in;
    logic        align;
    logic [7:0]  dataIn;
    logic [31:0] dataOut;
    logic        valid_out;
    logic [1:0]  byte_idx;

    modport slave (
        input  valid_in,
        input  align,
        input  dataIn,
        output dataOut,
        output valid_out,
        output byte_idx
    );

    modport master (
        output valid_in,
        output align,
        output dataIn,
        input  dataOut,
        input  valid_out,
        input  byte_idx
    );
endinterface

// File: rtl/conv_8_32.sv
// 8-to-32-bit deserializer: packs four accepted bytes into one word with a one-cycle valid pulse.
// The align input drops any partial word so that byte 0 can be re-synchronized to the transmitter.
module conv_8_32 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    conv_8_32_if.slave   bus
);
    logic [1:0]  r_idx;
    logic [23:0] r_acc;
    logic [31:0] r_data;
    logic        r_valid;

    logic [1:0]  w_idx_nxt;
    logic [23:0] w_acc_nxt;
    logic [31:0] w_data_nxt;
    logic        w_valid_nxt;

    // Byte k of the first three lands where it will sit in the finished word.
    function automatic logic [23:0] place_byte(input logic [23:0] acc,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  b);
        logic [23:0] res;
        res = acc;
        case (idx)
            2'd0: begin
                if (LSB_FIRST) res[7:0] = b;
                else           res[23:16] = b;
            end
            2'd1: res[15:8] = b;
            2'd2: begin
                if (LSB_FIRST) res[23:16] = b;
                else           res[7:0] = b;
            end
            default: res = acc;
        endcase
        return res;
    endfunction

    // Next-state: align restarts the word, byte 3 completes it, idle holds.
    always_comb begin
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        if (bus.align) begin
            if (bus.valid_in) begin
                w_acc_nxt = place_byte(24'd0, 2'd0, bus.dataIn);
                w_idx_nxt = 2'd1;
            end else begin
                w_acc_nxt = 24'd0;
                w_idx_nxt = 2'd0;
            end
        end else if (bus.valid_in) begin
            if (r_idx == 2'd3) begin
                if (LSB_FIRST) w_data_nxt = {bus.dataIn, r_acc};
                else           w_data_nxt = {r_acc, bus.dataIn};
                w_valid_nxt = 1'b1;
                w_idx_nxt   = 2'd0;
                w_acc_nxt   = 24'd0;
            end else begin
                w_acc_nxt = place_byte(r_acc, r_idx, bus.dataIn);
                w_idx_nxt = r_idx + 2'd1;
            end
        end else begin
            w_idx_nxt = r_idx;
            w_acc_nxt = r_acc;
        end
    end

    // State and output registers; reset overrides any same-cycle byte or align.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= 2'd0;
            r_acc   <= 24'd0;
            r_data  <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_acc   <= w_acc_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign bus.dataOut   = r_data;
    assign bus.valid_out = r_valid;
    assign bus.byte_idx  = r_idx;
endmodule

// File: tb/tb_conv_8_32.sv
// Bench for conv_8_32: both lane orders driven by one stimulus stream, checked by a
// byte-queue reference model feeding per-instance expected-word scoreboards.
module tb_conv_8_32;
    logic clk;
    logic reset;

    conv_8_32_if ifa ();
    conv_8_32_if ifb ();

    conv_8_32 #(.LSB_FIRST(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    conv_8_32 #(.LSB_FIRST(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [7:0]  m_bytes[$];
    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    logic [31:0] m_last_a = 32'd0;
    logic [31:0] m_last_b = 32'd0;
    logic        m_valid  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word is just the last four accepted bytes weighted by lane order.
    task automatic model_step(input logic r, input logic v, input logic a, input logic [7:0] d);
        logic [31:0] wa, wb;
        m_valid = 1'b0;
        if (r) begin
            m_bytes.delete();
            m_last_a = 32'd0;
            m_last_b = 32'd0;
        end else begin
            if (a) m_bytes.delete();
            if (v) m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
                wa = 32'd0;
                wb = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    wa = wa + (32'(m_bytes[k]) << (8 * k));
                    wb = wb + (32'(m_bytes[k]) << (24 - 8 * k));
                end
                exp_q_a.push_back(wa);
                exp_q_b.push_back(wb);
                m_last_a = wa;
                m_last_b = wb;
                m_valid  = 1'b1;
                m_bytes.delete();
            end
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic a, input logic [7:0] d);
        reset        = r;
        ifa.valid_in = v; ifa.align = a; ifa.dataIn = d;
        ifb.valid_in = v; ifb.align = a; ifb.dataIn = d;
        @(posedge clk);
        model_step(r, v, a, d);
        @(negedge clk);
    endtask

    // Monitor: compare every presented word against the scoreboard, plus per-cycle state.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("byte_idx_a", 32'(ifa.byte_idx), 32'(m_bytes.size()));
            chk("byte_idx_b", 32'(ifb.byte_idx), 32'(m_bytes.size()));
            chk("valid_out_a", 32'(ifa.valid_out), 32'(m_valid));
            chk("valid_out_b", 32'(ifb.valid_out), 32'(m_valid));
            chk("dataOut_hold_a", ifa.dataOut, m_last_a);
            chk("dataOut_hold_b", ifb.dataOut, m_last_b);
            if (ifa.valid_out === 1'b1) begin
                if (exp_q_a.size() == 0) chk("unexpected_word_a", ifa.dataOut, 32'hxxxxxxxx);
                else                     chk("word_a", ifa.dataOut, exp_q_a.pop_front());
            end
            if (ifb.valid_out === 1'b1) begin
                if (exp_q_b.size() == 0) chk("unexpected_word_b", ifb.dataOut, 32'hxxxxxxxx);
                else                     chk("word_b", ifb.dataOut, exp_q_b.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] w;
        logic        r, v, a;
        reset = 1'b1;
        ifa.valid_in = 1'b0; ifa.align = 1'b0; ifa.dataIn = 8'd0;
        ifb.valid_in = 1'b0; ifb.align = 1'b0; ifb.dataIn = 8'd0;
        @(negedge clk);

        // Reset for two cycles
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        mon_en = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 8'h5A);
        chk("reset_dataOut", ifa.dataOut, 32'd0);
        chk("reset_valid", 32'(ifa.valid_out), 32'd0);
        chk("reset_idx", 32'(ifa.byte_idx), 32'd0);

        // Four consecutive bytes
        cyc(1'b0, 1'b1, 1'b0, 8'h11);
        cyc(1'b0, 1'b1, 1'b0, 8'h22);
        cyc(1'b0, 1'b1, 1'b0, 8'h33);
        cyc(1'b0, 1'b1, 1'b0, 8'h44);
        chk("lsb_word", ifa.dataOut, 32'h44332211);
        chk("lsb_pulse", 32'(ifa.valid_out), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("lsb_pulse_width", 32'(ifa.valid_out), 32'd0);

        // Same bytes with gaps 0,3,1
        cyc(1'b0, 1'b1, 1'b0, 8'h11);
        cyc(1'b0, 1'b1, 1'b0, 8'h22);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'hFF);
        cyc(1'b0, 1'b1, 1'b0, 8'h33);
        cyc(1'b0, 1'b0, 1'b0, 8'hFF);
        cyc(1'b0, 1'b1, 1'b0, 8'h44);
        chk("msb_word", ifb.dataOut, 32'h11223344);
        chk("msb_pulse", 32'(ifb.valid_out), 32'd1);

        // Align drops a partial word
        cyc(1'b0, 1'b1, 1'b0, 8'hAA);
        cyc(1'b0, 1'b1, 1'b0, 8'hBB);
        cyc(1'b0, 1'b1, 1'b1, 8'h01);
        chk("align_idx", 32'(ifa.byte_idx), 32'd1);
        chk("align_no_pulse", 32'(ifa.valid_out), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h02);
        cyc(1'b0, 1'b1, 1'b0, 8'h03);
        cyc(1'b0, 1'b1, 1'b0, 8'h04);
        chk("align_word", ifa.dataOut, 32'h04030201);

        // Align on what would be byte 3 emits nothing
        cyc(1'b0, 1'b1, 1'b0, 8'h10);
        cyc(1'b0, 1'b1, 1'b0, 8'h20);
        cyc(1'b0, 1'b1, 1'b0, 8'h30);
        cyc(1'b0, 1'b0, 1'b1, 8'h40);
        chk("align_b3_no_pulse", 32'(ifa.valid_out), 32'd0);
        chk("align_b3_hold", ifa.dataOut, 32'h04030201);

        // Reset mid-word
        cyc(1'b0, 1'b1, 1'b0, 8'h91);
        cyc(1'b0, 1'b1, 1'b0, 8'h92);
        cyc(1'b0, 1'b1, 1'b0, 8'h93);
        cyc(1'b1, 1'b1, 1'b0, 8'h94);
        cyc(1'b0, 1'b1, 1'b0, 8'hDE);
        cyc(1'b0, 1'b1, 1'b0, 8'hAD);
        cyc(1'b0, 1'b1, 1'b0, 8'hBE);
        cyc(1'b0, 1'b1, 1'b0, 8'hEF);
        chk("reset_mid_word", ifa.dataOut, 32'hEFBEADDE);

        // Random traffic with occasional align and reset
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 14) == 0);
            cyc(r, v, a, 8'($urandom));
        end

        // Loopback from a byte-serial serializer at full rate
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        for (int n = 0; n < 16; n++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) begin
                cyc(1'b0, 1'b1, 1'b0, w[8*k +: 8]);
                if (k != 3) chk("loop_no_early_pulse", 32'(ifa.valid_out), 32'd0);
            end
            chk("loop_word", ifa.dataOut, w);
            chk("loop_pulse", 32'(ifa.valid_out), 32'd1);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("drain_a", 32'(exp_q_a.size()), 32'd0);
        chk("drain_b", 32'(exp_q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
